// File: rtl/led_out_device_pkg.sv
// Shared constants for the memory-mapped I/O devices: control-register bit
// positions (common to the switch, key and LED devices) and the LED display FSM states.
package led_out_device_pkg;

  localparam int unsigned READY_BIT   = 0;
  localparam int unsigned BUSY_BIT    = 1;
  localparam int unsigned OVERRUN_BIT = 2;
  localparam int unsigned DUTY_LSB    = 4;
  localparam int unsigned DUTY_WIDTH  = 4;
  localparam int unsigned IE_BIT      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dispState_t;

endpackage

// File: rtl/led_out_device_if.sv
// CPU data-bus view of a memory-mapped device: strobes, address, both data
// directions and the level-sensitive interrupt request.
interface led_out_device_if #(
  parameter int unsigned BITS = 32
);
  logic            we;
  logic            re;
  logic [BITS-1:0] memAddr;
  logic [BITS-1:0] dataBusIn;
  logic [BITS-1:0] dataBusOut;
  logic            intr;

  modport master (
    output we, re, memAddr, dataBusIn,
    input  dataBusOut, intr
  );

  modport slave (
    input  we, re, memAddr, dataBusIn,
    output dataBusOut, intr
  );
endinterface

// File: rtl/led_out_device_fifo.sv
// Synchronous FIFO used to queue LED patterns; DEPTH must be a power of two so
// the pointers wrap naturally, and the extra count bit separates full from empty.
module led_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/led_out_device.sv
// Memory-mapped LED output device: CPU writes queue patterns in a FIFO, each
// shown for at least HOLD_TIME cycles. Define LED_PWM_EN for duty-cycle dimming.
module led_out_device
  import led_out_device_pkg::*;
#(
  parameter int unsigned     LED_WIDTH  = 10,
  parameter int unsigned     BITS       = 32,
  parameter logic [BITS-1:0] BASE       = 32'hF0000000,
  parameter logic [BITS-1:0] CTRL_BASE  = 32'hF0000100,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     HOLD_TIME  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  led_out_device_if.slave      bus,
  output logic [LED_WIDTH-1:0] ledr
);
  localparam int unsigned HCW = $clog2(HOLD_TIME + 1);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

  logic                 dataWr, dataRd, ctrlWr, ctrlRd;
  logic                 fifoFull, fifoEmpty, pop;
  logic [FCW-1:0]       fifoCount;
  logic [LED_WIDTH-1:0] fifoHead;
  logic [LED_WIDTH-1:0] pattern;
  logic [HCW-1:0]       holdCnt;
  logic                 overrun, ie, intrReg;
  logic [BITS-1:0]      ctrl;
  dispState_t           state, nextState;

  assign dataWr = bus.we & (bus.memAddr == BASE);
  assign dataRd = bus.re & ~bus.we & (bus.memAddr == BASE);
  assign ctrlWr = bus.we & (bus.memAddr == CTRL_BASE);
  assign ctrlRd = bus.re & ~bus.we & (bus.memAddr == CTRL_BASE);

  led_fifo #(
    .WIDTH (LED_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dataWr),
    .pop   (pop),
    .din   (bus.dataBusIn[LED_WIDTH-1:0]),
    .dout  (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!fifoEmpty) nextState = HOLD;
      HOLD:    if (holdCnt == HCW'(HOLD_TIME - 1)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state == IDLE && !fifoEmpty) pop = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern <= '0;
      holdCnt <= '0;
    end else if (pop) begin
      pattern <= fifoHead;
      holdCnt <= '0;
    end else if (state == HOLD) begin
      holdCnt <= holdCnt + HCW'(1);
    end
  end

  // A write to a full FIFO is dropped even if the display pops that same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      if (dataWr && fifoFull)                          overrun <= 1'b1;
      else if (ctrlWr && !bus.dataBusIn[OVERRUN_BIT])  overrun <= 1'b0;
      if (ctrlWr) ie <= bus.dataBusIn[IE_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) intrReg <= 1'b0;
    else       intrReg <= ie & ~fifoFull;
  end
  assign bus.intr = intrReg;

`ifdef LED_PWM_EN
  logic [DUTY_WIDTH-1:0] duty;
  logic [DUTY_WIDTH-1:0] pwmCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      duty   <= '1;
      pwmCnt <= '0;
    end else begin
      pwmCnt <= pwmCnt + DUTY_WIDTH'(1);
      if (ctrlWr) duty <= bus.dataBusIn[DUTY_LSB +: DUTY_WIDTH];
    end
  end

  assign ledr = pattern & {LED_WIDTH{pwmCnt <= duty}};
`else
  assign ledr = pattern;
`endif

  always_comb begin
    ctrl              = '0;
    ctrl[READY_BIT]   = ~fifoFull;
    ctrl[BUSY_BIT]    = (state == HOLD) | ~fifoEmpty;
    ctrl[OVERRUN_BIT] = overrun;
    ctrl[IE_BIT]      = ie;
`ifdef LED_PWM_EN
    ctrl[DUTY_LSB +: DUTY_WIDTH] = duty;
`endif
  end

  always_comb begin
    bus.dataBusOut = '0;
    if (dataRd)      bus.dataBusOut = BITS'(pattern);
    else if (ctrlRd) bus.dataBusOut = ctrl;
  end

endmodule

// File: tb/tb_led_out_device.sv
// Directed self-checking bench for led_out_device (default parameters); the
// duty-cycle checks switch on with LED_PWM_EN.
module tb_led_out_device;
  localparam logic [31:0] BASE      = 32'hF0000000;
  localparam logic [31:0] CTRL_BASE = 32'hF0000100;
`ifdef LED_PWM_EN
  localparam logic [31:0] DE = 32'h000000F0;
`else
  localparam logic [31:0] DE = 32'h00000000;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] ledr;
  int         total = 0;
  int         bad = 0;

  led_out_device_if #(.BITS(32)) bus ();

  led_out_device #(
    .LED_WIDTH  (10),
    .BITS       (32),
    .BASE       (BASE),
    .CTRL_BASE  (CTRL_BASE),
    .FIFO_DEPTH (4),
    .HOLD_TIME  (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .ledr  (ledr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    bus.we = 1'b1; bus.memAddr = addr; bus.dataBusIn = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0; bus.dataBusIn = '0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    bus.re = 1'b1; bus.memAddr = addr;
    #1;
    data = bus.dataBusOut;
    bus.re = 1'b0; bus.memAddr = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.memAddr = '0; bus.dataBusIn = '0;
    waitEdges(3);
    reset = 1'b0;
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h1 | DE)) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h1 | DE); end
    total++; if (ledr !== 10'h0) begin bad++; $display("FAIL reset_ledr got=%h exp=0", ledr); end
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", bus.intr); end
    bus.memAddr = 32'h1234; #1;
    total++; if (bus.dataBusOut !== 32'h0) begin bad++; $display("FAIL unselected_out got=%h exp=0", bus.dataBusOut); end
  endtask

  task automatic test_single_write();
    logic [31:0] d;
    busWrite(BASE, 32'h155);
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h3 | DE)) begin bad++; $display("FAIL single_ctrl_t got=%h exp=%h", d, 32'h3 | DE); end
    total++; if (ledr !== 10'h0) begin bad++; $display("FAIL single_ledr_t got=%h exp=0", ledr); end
    waitEdges(1);
    total++; if (ledr !== 10'h155) begin bad++; $display("FAIL single_ledr_t1 got=%h exp=155", ledr); end
    busRead(BASE, d);
    total++; if (d !== 32'h155) begin bad++; $display("FAIL single_data_rd got=%h exp=155", d); end
    waitEdges(15);
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h3 | DE)) begin bad++; $display("FAIL single_busy_t16 got=%h exp=%h", d, 32'h3 | DE); end
    waitEdges(1);
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h1 | DE)) begin bad++; $display("FAIL single_idle_t17 got=%h exp=%h", d, 32'h1 | DE); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 1; i <= 6; i++) busWrite(BASE, 32'(i));
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h6 | DE)) begin bad++; $display("FAIL ovf_ctrl_full got=%h exp=%h", d, 32'h6 | DE); end
    total++; if (ledr !== 10'd1) begin bad++; $display("FAIL ovf_first got=%h exp=1", ledr); end
    waitEdges(12);
    total++; if (ledr !== 10'd1) begin bad++; $display("FAIL ovf_hold1 got=%h exp=1", ledr); end
    waitEdges(1);
    total++; if (ledr !== 10'd2) begin bad++; $display("FAIL ovf_pat2 got=%h exp=2", ledr); end
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h7 | DE)) begin bad++; $display("FAIL ovf_ready_back got=%h exp=%h", d, 32'h7 | DE); end
    for (int k = 2; k <= 4; k++) begin
      waitEdges(16);
      total++; if (ledr !== 10'(k)) begin bad++; $display("FAIL ovf_hold%0d got=%h exp=%h", k, ledr, 10'(k)); end
      waitEdges(1);
      total++; if (ledr !== 10'(k + 1)) begin bad++; $display("FAIL ovf_pat%0d got=%h exp=%h", k + 1, ledr, 10'(k + 1)); end
    end
    waitEdges(20);
    total++; if (ledr !== 10'd5) begin bad++; $display("FAIL ovf_dropped got=%h exp=5", ledr); end
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h5 | DE)) begin bad++; $display("FAIL ovf_ctrl_end got=%h exp=%h", d, 32'h5 | DE); end
  endtask

  task automatic test_overrun_clear();
    logic [31:0] d;
    busWrite(CTRL_BASE, 32'h1F4);
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h105 | DE)) begin bad++; $display("FAIL ovr_write1 got=%h exp=%h", d, 32'h105 | DE); end
    busWrite(CTRL_BASE, 32'h1F0);
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h101 | DE)) begin bad++; $display("FAIL ovr_clear got=%h exp=%h", d, 32'h101 | DE); end
    waitEdges(1);
    total++; if (bus.intr !== 1'b1) begin bad++; $display("FAIL ovr_intr got=%b exp=1", bus.intr); end
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) busWrite(BASE, 32'h0A0 + 32'(i));
    waitEdges(1);
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL int_full got=%b exp=0", bus.intr); end
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h102 | DE)) begin bad++; $display("FAIL int_ctrl_full got=%h exp=%h", d, 32'h102 | DE); end
    waitEdges(12);
    total++; if (ledr !== 10'h0A0) begin bad++; $display("FAIL int_pat0 got=%h exp=0a0", ledr); end
    busWrite(BASE, 32'h0FF);
    total++; if (ledr !== 10'h0A1) begin bad++; $display("FAIL int_pat1 got=%h exp=0a1", ledr); end
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL int_lag got=%b exp=0", bus.intr); end
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h107 | DE)) begin bad++; $display("FAIL int_drop_on_pop got=%h exp=%h", d, 32'h107 | DE); end
    waitEdges(1);
    total++; if (bus.intr !== 1'b1) begin bad++; $display("FAIL int_rearm got=%b exp=1", bus.intr); end
    waitEdges(16);
    total++; if (ledr !== 10'h0A2) begin bad++; $display("FAIL int_pat2 got=%h exp=0a2", ledr); end
    waitEdges(60);
    total++; if (ledr !== 10'h0A4) begin bad++; $display("FAIL int_last got=%h exp=0a4", ledr); end
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h105 | DE)) begin bad++; $display("FAIL int_ctrl_end got=%h exp=%h", d, 32'h105 | DE); end
  endtask

  task automatic test_pwm();
    logic [31:0] d;
    int onCnt;
    int other;
    busWrite(CTRL_BASE, 32'h130);
    busRead(CTRL_BASE, d);
`ifdef LED_PWM_EN
    total++; if (d !== 32'h131) begin bad++; $display("FAIL pwm_ctrl got=%h exp=131", d); end
`else
    total++; if (d !== 32'h101) begin bad++; $display("FAIL pwm_ctrl got=%h exp=101", d); end
`endif
    busWrite(BASE, 32'h3FF);
    onCnt = 0; other = 0;
    for (int i = 0; i < 16; i++) begin
      waitEdges(1);
      if (ledr === 10'h3FF) onCnt++;
      else if (ledr !== 10'h0) other++;
    end
`ifdef LED_PWM_EN
    total++; if (onCnt !== 4) begin bad++; $display("FAIL pwm_on_cycles got=%0d exp=4", onCnt); end
`else
    total++; if (onCnt !== 16) begin bad++; $display("FAIL pwm_on_cycles got=%0d exp=16", onCnt); end
`endif
    total++; if (other !== 0) begin bad++; $display("FAIL pwm_partial got=%0d exp=0", other); end
    busRead(BASE, d);
    total++; if (d !== 32'h3FF) begin bad++; $display("FAIL pwm_data_rd got=%h exp=3ff", d); end
  endtask

  task automatic test_reset_mid_hold();
    logic [31:0] d;
    busWrite(BASE, 32'h011);
    busWrite(BASE, 32'h022);
    busWrite(BASE, 32'h033);
    waitEdges(5);
    reset = 1'b1;
    waitEdges(1);
    reset = 1'b0;
    total++; if (ledr !== 10'h0) begin bad++; $display("FAIL rst_hold_ledr got=%h exp=0", ledr); end
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL rst_hold_intr got=%b exp=0", bus.intr); end
    busRead(CTRL_BASE, d);
    total++; if (d !== (32'h1 | DE)) begin bad++; $display("FAIL rst_hold_ctrl got=%h exp=%h", d, 32'h1 | DE); end
    waitEdges(20);
    total++; if (ledr !== 10'h0) begin bad++; $display("FAIL rst_flushed got=%h exp=0", ledr); end
    total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL rst_ie_cleared got=%b exp=0", bus.intr); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_overrun_clear();
    test_interrupt();
    test_pwm();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
